// File: rtl/gear_pkg.sv
// rtl/gear_pkg.sv - shared GeAr sizing functions and parameter legality check
package gear_pkg;

  function automatic int gear_len(input int r, input int p);
    return r + p;
  endfunction

  function automatic int gear_cnt(input int n, input int r, input int p);
    return (n - gear_len(r, p)) / r + 1;
  endfunction

  // Every sub-adder must land on whole R-bit result slices inside the word.
  function automatic bit gear_legal(input int n, input int r, input int p);
    if (r < 1 || p < 0) return 1'b0;
    if (gear_len(r, p) > n) return 1'b0;
    return ((n - gear_len(r, p)) % r) == 0;
  endfunction

endpackage

// File: rtl/gear_subadder.sv
// rtl/gear_subadder.sv - L-bit ripple-carry adder used as one GeAr sub-adder
module gear_subadder #(
  parameter int L = 8
) (
  input  logic [L-1:0] a,
  input  logic [L-1:0] b,
  input  logic         cin,
  output logic [L-1:0] sum,
  output logic         cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < L; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/ge_ar.sv
// rtl/ge_ar.sv - registered GeAr approximate adder; GEAR_ERR_DETECT_EN adds ERR output
module ge_ar
  import gear_pkg::*;
#(
  parameter int N = 16,
  parameter int R = 2,
  parameter int P = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [N:1] A,
  input  logic [N:1] B,
  input  logic       CIN,
  output logic [N:1] SUM,
`ifdef GEAR_ERR_DETECT_EN
  output logic       ERR,
`endif
  output logic       COUT
);

  localparam int L = gear_len(R, P);
  localparam int K = gear_cnt(N, R, P);

  if (!gear_legal(N, R, P)) begin : g_illegal
    $fatal(1, "ge_ar: illegal N/R/P combination");
  end

  logic [N-1:0] a, b, sum_c;
  logic         cout_c;

  assign a = A;
  assign b = B;

  for (genvar i = 0; i < K; i++) begin : g_sub
    logic [L-1:0] s;
    logic         co;

    gear_subadder #(.L(L)) u_sub (
      .a   (a[i*R +: L]),
      .b   (b[i*R +: L]),
      .cin ((i == 0) ? CIN : 1'b0),
      .sum (s),
      .cout(co)
    );

    // Sub-adder 0 owns the whole low window; later ones contribute only their top R bits.
    if (i == 0) begin : g_first
      assign sum_c[L-1:0] = s;
    end else begin : g_rest
      assign sum_c[i*R+P +: R] = s[L-1 -: R];
      if (P > 0) begin : g_pred
        logic [P-1:0] unused_pred;
        assign unused_pred = s[P-1:0];
      end
    end

    if (i == K - 1) begin : g_last
      assign cout_c = co;
    end else begin : g_mid
      logic unused_co;
      assign unused_co = co;
    end
  end

`ifdef GEAR_ERR_DETECT_EN
  logic [N:0] exact;
  assign exact = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, CIN};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      SUM  <= '0;
      COUT <= 1'b0;
`ifdef GEAR_ERR_DETECT_EN
      ERR  <= 1'b0;
`endif
    end else begin
      SUM  <= sum_c;
      COUT <= cout_c;
`ifdef GEAR_ERR_DETECT_EN
      ERR  <= ({cout_c, sum_c} != exact);
`endif
    end
  end

endmodule

// File: tb/tb_ge_ar.sv
// tb/tb_ge_ar.sv - self-checking bench for ge_ar: directed vectors plus random vs. masked-window model
module tb_ge_ar;

  localparam int N = 16;
  localparam int R = 2;
  localparam int P = 6;
  localparam int L = R + P;
  localparam int K = (N - L) / R + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N:1]   a_in, b_in, sum;
  logic         cin, cout;
`ifdef GEAR_ERR_DETECT_EN
  logic         err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ge_ar #(.N(N), .R(R), .P(P)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a_in),
    .B   (b_in),
    .CIN (cin),
    .SUM (sum),
`ifdef GEAR_ERR_DETECT_EN
    .ERR (err),
`endif
    .COUT(cout)
  );

  // Result bit j equals bit j of the exact sum of the operands with every bit
  // below that bit's look-back start zeroed (start 0 keeps CIN).
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    logic [N:0] res;
    longint     t, m;
    int         s;
    res = '0;
    for (int j = 0; j <= N; j++) begin
      if (j == N)     s = (K - 1) * R;
      else if (j < L) s = 0;
      else            s = ((j - P) / R) * R;
      m = ~((64'sd1 <<< s) - 1);
      t = (longint'(a) & m) + (longint'(b) & m) + ((s == 0) ? longint'(c) : 64'sd0);
      res[j] = t[j];
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    rst  = r;
    a_in = a;
    b_in = b;
    cin  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] s, input logic co, input logic e);
    chk({tag, "_sum"}, 32'(sum), 32'(s));
    chk({tag, "_cout"}, 32'(cout), 32'(co));
`ifdef GEAR_ERR_DETECT_EN
    chk({tag, "_err"}, 32'(err), 32'(e));
`else
    if (e !== 1'bx) begin end
`endif
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic         rc;
    logic [N:0]   ap, ex;

    // Reset held over two edges with all-ones operands.
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    expect_out("reset0", 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    expect_out("reset1", 16'h0000, 1'b0, 1'b0);

    // Back-to-back directed vectors, one result per cycle.
    step(1'b0, 16'h1234, 16'h0101, 1'b1);
    expect_out("exact", 16'h1336, 1'b0, 1'b0);
    step(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    expect_out("gen_chain", 16'hFFFE, 1'b1, 1'b0);
    step(1'b0, 16'h0080, 16'h0080, 1'b0);
    expect_out("pred_window", 16'h0100, 1'b0, 1'b0);
    step(1'b0, 16'h00FF, 16'h0001, 1'b0);
    expect_out("lost_carry", 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'hFFFF, 16'h0000, 1'b1);
    expect_out("cin_lost", 16'hFF00, 1'b0, 1'b1);

    // Mid-stream reset discards the in-flight result; held inputs reappear next cycle.
    step(1'b1, 16'h1234, 16'h0101, 1'b1);
    expect_out("mid_reset", 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h1234, 16'h0101, 1'b1);
    expect_out("post_reset", 16'h1336, 1'b0, 1'b0);

    // Random operands against the model, with the exact sum deciding ERR.
    for (int i = 0; i < 300; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
      if (i % 5 == 0) rb = ~ra;
      ap = model(ra, rb, rc);
      ex = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
      step(1'b0, ra, rb, rc);
      expect_out($sformatf("rand%0d", i), ap[N-1:0], ap[N], ap != ex);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ge_ar.md
# ge_ar

- Registered Generic Accuracy-configurable Adder (GeAr) for approximate-arithmetic datapaths.
- Adds two N-bit operands plus carry-in using overlapping short sub-adders instead of one full carry chain, trading exactness for shorter critical path.
- Sits between operand registers and downstream approximate-compute logic.
- Result and carry-out are registered; latency is one clock.

## Interface
- N, default 16: operand/sum width.
- R, default 2: result bits produced per speculative sub-adder.
- P, default 6: prediction (carry-look-back) bits per sub-adder.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  N  operand A, declared [N:1], bit 1 = LSB.
- B  input  N  operand B, declared [N:1], bit 1 = LSB.
- CIN  input  1  carry-in into bit 1.
- SUM  output  N  registered approximate sum, [N:1].
- COUT  output  1  registered approximate carry-out.
- ERR  output  1  registered error flag, present only with GEAR_ERR_DETECT_EN.

## Operation
- Derived constants:
  - L = R+P (sub-adder length).
  - K = (N−L)/R + 1 (number of sub-adders).
- Elaboration-time checks (fatal error if violated):
  - (N−L) mod R = 0.
  - L ≤ N, R ≥ 1, P ≥ 0.
- Bit positions below use 0-based offset j (port bit j+1).
- Sub-adder 0:
  - L-bit ripple add of bits 0..L−1 with carry-in CIN.
  - All L sum bits go to SUM bits 0..L−1.
- Sub-adder i, 1 ≤ i < K:
  - L-bit add of bits i·R..i·R+L−1 with carry-in 0.
  - Low P sum bits are discarded (prediction only).
  - High R sum bits drive SUM bits i·R+P..i·R+L−1.
- COUT = carry-out of sub-adder K−1 (carry-out of sub-adder 0 when K=1).
- Carries generated or killed within the P-bit window are exact. A carry entering from below bit i·R and propagating through all P prediction bits is lost.
- With P = N−R (K=1), the block is an exact adder.
- Unsigned arithmetic; no overflow flag beyond COUT.

## Timing
- Combinational approximate result is captured at each rising clk; SUM/COUT valid one cycle after A/B/CIN are presented.
- No handshake; a new operand set is accepted every cycle (throughput 1/cycle).
- rst high at a rising edge: SUM=0, COUT=0, ERR=0 on that edge, overriding the computed result.
- Reset mid-stream: the in-flight result is discarded. The first post-reset result appears one cycle after rst deasserts with inputs held.
- Inputs need only meet setup/hold at clk; no internal state besides the output registers.

## Configuration
- GEAR_ERR_DETECT_EN defined:
  - Adds ERR port and an exact N-bit reference adder.
  - ERR is registered alongside SUM/COUT.
  - ERR=1 iff {COUT,SUM} ≠ exact A+B+CIN for the same cycle's inputs.
- GEAR_ERR_DETECT_EN undefined: no ERR port, no reference adder; behaviour otherwise identical.

## Structure
- Shared package gear_pkg holds:
  - Functions computing L and K from N, R, P.
  - The parameter-legality check.
- One sub-module gear_subadder:
  - Parameterized L-bit ripple adder with carry-in, sum and carry-out.
  - Instantiated K times via generate.
- Top level holds the generate loop, result-bit selection, output registers, and the optional exact reference.

## Test plan
(Defaults N=16, R=2, P=6, GEAR_ERR_DETECT_EN defined; hex values.)
- Reset: rst=1 with A=FFFF, B=FFFF -> next edge SUM=0000, COUT=0, ERR=0; hold until rst drops.
- Exact, no long carries: A=1234, B=0101, CIN=1 -> one cycle later SUM=1336, COUT=0, ERR=0.
- Generate chain: A=FFFF, B=FFFF, CIN=0 -> SUM=FFFE, COUT=1, ERR=0.
- Carry inside prediction window: A=0080, B=0080, CIN=0 -> SUM=0100, COUT=0, ERR=0.
- Lost carry: A=00FF, B=0001, CIN=0 -> SUM=0000, COUT=0, ERR=1 (exact 0100).
- CIN lost through propagate chain: A=FFFF, B=0000, CIN=1 -> SUM=FF00, COUT=0, ERR=1 (exact 1_0000).
- Back-to-back: the above vectors on consecutive cycles produce their results on consecutive cycles with no bubbles.
